// File: rtl/cpu_checker_pkg.sv
// Shared types and constants for the byte-serial trace-line checker.
// Holds the parser state encoding, ASCII delimiters, format codes and error bit positions.
package cpu_checker_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_CARET, S_TIME, S_PC, S_COLON, S_SP1, S_REG0, S_REG,
        S_ADDR, S_SP2, S_EQ, S_SP3, S_DATA, S_HASH, S_DONE
    } state_e;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LT     = 8'h3C;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    localparam logic [1:0] FMT_NONE = 2'b00;
    localparam logic [1:0] FMT_REG  = 2'b01;
    localparam logic [1:0] FMT_MEM  = 2'b10;

    localparam int ERR_TIME = 0;
    localparam int ERR_PC   = 1;
    localparam int ERR_ADDR = 2;
    localparam int ERR_GRF  = 3;

    // Window test written as an offset compare so a zero lower bound does not
    // collapse into a constant comparison; also flags non-word-aligned values.
    function automatic logic out_of_window(logic [31:0] v, logic [31:0] lo, logic [31:0] hi);
        return ((v - lo) > (hi - lo)) || (v[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/char_class.sv
// Combinational ASCII classifier: decimal digit, hex digit and the digit's nibble value.
module char_class (
    input  logic [7:0] char_i,
    output logic       is_dec_o,
    output logic       is_hex_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        is_dec_o = 1'b0;
        is_hex_o = 1'b0;
        nibble_o = 4'h0;
        if (char_i >= 8'h30 && char_i <= 8'h39) begin
            is_dec_o = 1'b1;
            is_hex_o = 1'b1;
            nibble_o = char_i[3:0];
        end else if ((char_i >= 8'h61 && char_i <= 8'h66) ||
                     (char_i >= 8'h41 && char_i <= 8'h46)) begin
            // 'a'/'A' carry 1 in the low nibble, so +9 yields 10..15
            is_hex_o = 1'b1;
            nibble_o = 4'(char_i[3:0] + 4'd9);
        end
    end

endmodule

// File: rtl/cpu_checker_param.sv
// Byte-serial checker for register/memory write trace records with a saturating record counter.
// Parser FSM, accumulators, error evaluation and counter; outputs are fully registered.
module cpu_checker_param
    import cpu_checker_pkg::*;
#(
    parameter int          TIME_DIGITS = 4,
    parameter int          GRF_DIGITS  = 4,
    parameter int          NREG        = 32,
    parameter logic [31:0] PC_LO       = 32'h0000_3000,
    parameter logic [31:0] PC_HI       = 32'h0000_4FFF,
    parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI     = 32'h0000_2FFF,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic [15:0]      freq,
    output logic [1:0]       format_type,
    output logic [3:0]       error_code,
    output logic [CNT_W-1:0] record_cnt
);

    state_e           state_q, state_d;
    logic [31:0]      time_q, time_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      addr_q, addr_d;
    logic [13:0]      reg_q, reg_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic             mem_q, mem_d;
    logic [1:0]       fmt_q, fmt_d;
    logic [3:0]       err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       is_dec, is_hex;
    logic [3:0] nib;
    logic [15:0] time_mask;
    logic        is_space;

    char_class u_cls (
        .char_i   (char),
        .is_dec_o (is_dec),
        .is_hex_o (is_hex),
        .nibble_o (nib)
    );

    assign time_mask = 16'(freq >> 1) - 16'd1;
    assign is_space  = (char == CH_SPACE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            time_q  <= '0;
            pc_q    <= '0;
            addr_q  <= '0;
            reg_q   <= '0;
            dcnt_q  <= '0;
            mem_q   <= 1'b0;
            fmt_q   <= FMT_NONE;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            dcnt_q  <= dcnt_d;
            mem_q   <= mem_d;
            fmt_q   <= fmt_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        time_d  = time_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        reg_d   = reg_q;
        dcnt_d  = dcnt_q;
        mem_d   = mem_q;
        fmt_d   = FMT_NONE;
        err_d   = '0;
        cnt_d   = cnt_q;

        if (char == CH_CARET) begin
            state_d = S_CARET;
            time_d  = '0;
            pc_d    = '0;
            addr_d  = '0;
            reg_d   = '0;
            dcnt_d  = '0;
            mem_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_CARET: if (is_dec) begin
                    state_d = S_TIME;
                    time_d  = {28'd0, nib};
                    dcnt_d  = 4'd1;
                end
                S_TIME: if (is_dec && dcnt_q < 4'(TIME_DIGITS)) begin
                    state_d = S_TIME;
                    time_d  = 32'(time_q * 32'd10) + {28'd0, nib};
                    dcnt_d  = dcnt_q + 4'd1;
                end else if (char == CH_AT) begin
                    state_d = S_PC;
                    dcnt_d  = '0;
                end
                S_PC: if (is_hex) begin
                    pc_d    = {pc_q[27:0], nib};
                    dcnt_d  = dcnt_q + 4'd1;
                    state_d = (dcnt_q == 4'd7) ? S_COLON : S_PC;
                end
                S_COLON: if (char == CH_COLON) state_d = S_SP1;
                S_SP1: if (is_space) begin
                    state_d = S_SP1;
                end else if (char == CH_DOLLAR) begin
                    state_d = S_REG0;
                    mem_d   = 1'b0;
                end else if (char == CH_STAR) begin
                    state_d = S_ADDR;
                    mem_d   = 1'b1;
                    dcnt_d  = '0;
                end
                // Padding between '$' and the register number is tolerated
                S_REG0: if (is_space) begin
                    state_d = S_REG0;
                end else if (is_dec) begin
                    state_d = S_REG;
                    reg_d   = {10'd0, nib};
                    dcnt_d  = 4'd1;
                end
                S_REG: if (is_dec && dcnt_q < 4'(GRF_DIGITS)) begin
                    state_d = S_REG;
                    reg_d   = 14'(reg_q * 14'd10) + {10'd0, nib};
                    dcnt_d  = dcnt_q + 4'd1;
                end else if (is_space) begin
                    state_d = S_SP2;
                end else if (char == CH_LT) begin
                    state_d = S_EQ;
                end
                S_ADDR: if (is_hex && dcnt_q < 4'd8) begin
                    state_d = S_ADDR;
                    addr_d  = {addr_q[27:0], nib};
                    dcnt_d  = dcnt_q + 4'd1;
                end else if (dcnt_q == 4'd8 && is_space) begin
                    state_d = S_SP2;
                end else if (dcnt_q == 4'd8 && char == CH_LT) begin
                    state_d = S_EQ;
                end
                S_SP2: if (is_space) state_d = S_SP2;
                       else if (char == CH_LT) state_d = S_EQ;
                S_EQ: if (char == CH_EQ) state_d = S_SP3;
                S_SP3: if (is_space) begin
                    state_d = S_SP3;
                end else if (is_hex) begin
                    state_d = S_DATA;
                    dcnt_d  = 4'd1;
                end
                S_DATA: if (is_hex) begin
                    dcnt_d  = dcnt_q + 4'd1;
                    state_d = (dcnt_q == 4'd7) ? S_HASH : S_DATA;
                end
                S_HASH: if (char == CH_HASH) begin
                    state_d           = S_DONE;
                    fmt_d             = mem_q ? FMT_MEM : FMT_REG;
                    err_d[ERR_TIME]   = |(time_q[15:0] & time_mask);
                    err_d[ERR_PC]     = out_of_window(pc_q, PC_LO, PC_HI);
                    err_d[ERR_ADDR]   = mem_q && out_of_window(addr_q, ADDR_LO, ADDR_HI);
                    err_d[ERR_GRF]    = !mem_q && ({18'd0, reg_q} >= 32'(NREG));
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign format_type = fmt_q;
    assign error_code  = err_q;
    assign record_cnt  = cnt_q;

endmodule

// File: tb/tb_cpu_checker_param.sv
// Scoreboard bench: the driver queues the expected result of every complete record,
// and a monitor pops and compares whenever either checker reports a record.
module tb_cpu_checker_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ch;
    logic [15:0] freq;
    logic [1:0]  format_type, fmt2;
    logic [3:0]  error_code, err2;
    logic [15:0] record_cnt;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [1:0] fmt;
        logic [3:0] err;
        int         cnt;
        int         cnt2;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    cpu_checker_param dut (
        .clk(clk), .reset(reset), .char(ch), .freq(freq),
        .format_type(format_type), .error_code(error_code), .record_cnt(record_cnt)
    );

    cpu_checker_param #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .char(ch), .freq(freq),
        .format_type(fmt2), .error_code(err2), .record_cnt(cnt2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        ch = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic expect_rec(input logic [1:0] fmt, input logic [3:0] err);
        exp_t e;
        exp_cnt++;
        e.fmt  = fmt;
        e.err  = err;
        e.cnt  = exp_cnt;
        e.cnt2 = (exp_cnt > 3) ? 3 : exp_cnt;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_char(8'h0a);
    endtask

    always @(negedge clk) begin
        if (!reset && (format_type != 2'b00 || fmt2 != 2'b00)) begin
            if (q.size() == 0) begin
                chk("unexpected_record", int'(format_type), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("format_type", int'(format_type), int'(e.fmt));
                chk("error_code",  int'(error_code),  int'(e.err));
                chk("record_cnt",  int'(record_cnt),  e.cnt);
                chk("format_type_sat", int'(fmt2), int'(e.fmt));
                chk("error_code_sat",  int'(err2), int'(e.err));
                chk("record_cnt_sat",  int'(cnt2), e.cnt2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        ch    = 8'h0a;
        freq  = 16'd4;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_format", int'(format_type), 0);
        chk("reset_error",  int'(error_code), 0);
        chk("reset_cnt",    int'(record_cnt), 0);
        reset = 1'b0;
        idle(2);

        // Reset lands in the PC digits; the tail must not complete a record
        send_str("^10@0000");
        reset = 1'b1;
        #1;
        chk("midrec_reset_format", int'(format_type), 0);
        chk("midrec_reset_cnt",    int'(record_cnt), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_str("3000: $ 5 <= 0000000a#");
        idle(3);

        freq = 16'd4;
        expect_rec(2'b01, 4'b0000);
        send_str("^10@00003000: $ 5 <= 0000000a#");
        idle(3);

        expect_rec(2'b10, 4'b0111);
        send_str("^3@00002ffc: *00003000 <= 12345678#");
        idle(3);

        freq = 16'd16;
        expect_rec(2'b01, 4'b1000);
        send_str("^8@00003004: $40 <= 00000000#");
        idle(3);

        // Five time digits overflow TIME_DIGITS=4: no report
        send_str("^12345@00003000: $1 <= 00000000#");
        idle(3);

        // Restart mid-record; the fresh record has time 7 with freq 4 -> time error
        freq = 16'd4;
        expect_rec(2'b01, 4'b0001);
        send_str("^10@00003000: $ 5 <= 00^7@00003000: $3 <= 0000000a#");
        idle(3);

        // Second record begins in the cycle the first one reports
        freq = 16'd8;
        expect_rec(2'b01, 4'b0000);
        expect_rec(2'b10, 4'b0000);
        send_str("^16@00003008: $31 <= deadBEEF#^20@0000300c: *00002ffc <= 00000000#");
        idle(3);

        chk("queue_drained", q.size(), 0);
        chk("final_cnt",     int'(record_cnt), 6);
        chk("final_cnt_sat", int'(cnt2), 3);

        // Reset while a completed record is being shown clears outputs at once
        send_str("^4@00003000: $1 <= 00000000#");
        reset = 1'b1;
        #1;
        chk("async_clear_format", int'(format_type), 0);
        chk("async_clear_error",  int'(error_code), 0);
        chk("async_clear_cnt",    int'(record_cnt), 0);
        chk("async_clear_cnt_sat", int'(cnt2), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
